// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths and receiver state encoding for the I2S receive path
package i2s_pkg;
    localparam int SAMPLE_BITS_DEF = 24;
    localparam int SLOT_BITS_DEF   = 32;
    localparam int FRAME_BITS      = 2 * SAMPLE_BITS_DEF;
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} rx_state_t;
endpackage

// File: rtl/i2s_input_sync.sv
// i2s_input_sync: 2-FF synchronisers for bclk/lrclk/sdata plus a bclk rising-edge strobe
module i2s_input_sync (
    input  logic clk,
    input  logic arst,
    input  logic bclk,
    input  logic lrclk,
    input  logic sdata,
    output logic rise,
    output logic lrclk_s,
    output logic sdata_s
);
    logic [2:0] bclk_q;
    logic [1:0] lrclk_q;
    logic [1:0] sdata_q;
    // two synchroniser stages per pin; bclk keeps a third stage for edge detection
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bclk_q  <= '0;
            lrclk_q <= '0;
            sdata_q <= '0;
        end else begin
            bclk_q  <= {bclk_q[1:0], bclk};
            lrclk_q <= {lrclk_q[0], lrclk};
            sdata_q <= {sdata_q[0], sdata};
        end
    end
    assign rise    = bclk_q[1] & ~bclk_q[2];
    assign lrclk_s = lrclk_q[1];
    assign sdata_s = sdata_q[1];
endmodule

// File: rtl/i2s_slave_receiver.sv
// i2s_slave_receiver: I2S deserialiser presenting {left,right} frames on valid/ready;
// define I2S_RX_FRAMEERR_EN to add the slot-length check and its frame_err pulse
module i2s_slave_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int SLOT_BITS   = SLOT_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     i2s_bclk,
    input  logic                     i2s_lrclk,
    input  logic                     i2s_sdata,
    output logic [2*SAMPLE_BITS-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
`ifdef I2S_RX_FRAMEERR_EN
    output logic                     frame_err,
`endif
    input  logic                     overflow_clr
);
    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_BITS);
    localparam logic [SAMPLE_BITS-1:0] MSB_ONE = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

    logic                     rise, lrclk_s, sdata_s;
    logic                     lr_prev_q;
    logic [CW-1:0]            bit_cnt_q;
    logic [SAMPLE_BITS-1:0]   shreg_q, shreg_cap, left_hold_q;
    rx_state_t                state_q, state_d;
    logic                     lr_edge, latch_left, frame_done;
    logic                     take, load;
    logic [2*SAMPLE_BITS-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overflow_q, overflow_d;

    i2s_input_sync u_sync (
        .clk     (clk),
        .arst    (arst),
        .bclk    (i2s_bclk),
        .lrclk   (i2s_lrclk),
        .sdata   (i2s_sdata),
        .rise    (rise),
        .lrclk_s (lrclk_s),
        .sdata_s (sdata_s)
    );

    // current bit merged into the shift register; a slot edge latches this merged value
    // because the one-bit-delay bit still belongs to the slot that is ending
    always_comb begin
        lr_edge   = rise && (lrclk_s != lr_prev_q);
        shreg_cap = (bit_cnt_q < CNT_MAX) ? (shreg_q | ({SAMPLE_BITS{sdata_s}} & (MSB_ONE >> bit_cnt_q))) : shreg_q;
    end

    // bit capture, slot restart and left-channel hold, all advancing on bclk rise
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            lr_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
        end else if (rise) begin
            lr_prev_q <= lrclk_s;
            shreg_q   <= lr_edge ? '0 : shreg_cap;
            bit_cnt_q <= lr_edge ? '0 : ((bit_cnt_q < CNT_MAX) ? bit_cnt_q + 1'b1 : bit_cnt_q);
            if (latch_left) left_hold_q <= shreg_cap;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= SYNC;
        else      state_q <= state_d;
    end

    // FSM next state: SYNC waits for the first lrclk fall so a partial frame is never emitted
    always_comb begin
        state_d = state_q;
        if (lr_edge) begin
            unique case (state_q)
                SYNC:    state_d = lrclk_s ? SYNC : LEFT;
                LEFT:    state_d = lrclk_s ? RIGHT : LEFT;
                RIGHT:   state_d = lrclk_s ? RIGHT : LEFT;
                default: state_d = SYNC;
            endcase
        end
    end

    // FSM outputs: left-sample latch on lrclk rise, frame completion on lrclk fall
    always_comb begin
        latch_left = lr_edge && (state_q == LEFT) && lrclk_s;
        frame_done = lr_edge && (state_q == RIGHT) && !lrclk_s;
    end

    // output handshake: load when the slot is free or emptying this cycle, else drop and flag
    always_comb begin
        take        = out_valid_q && out_ready;
        load        = frame_done && (!out_valid_q || out_ready);
        out_valid_d = load || (out_valid_q && !take);
        out_data_d  = load ? {left_hold_q, shreg_cap} : out_data_q;
        overflow_d  = (frame_done && !load) || (overflow_q && !overflow_clr);
    end

    // output registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

`ifdef I2S_RX_FRAMEERR_EN
    localparam int SW = $clog2(SLOT_BITS + 1) + 1;
    localparam logic [SW-1:0] SLOT_LEN = SW'(SLOT_BITS);
    logic [SW-1:0] slot_cnt_q;
    logic          frame_err_q;
    // slot length runs MSB rise through delay-bit rise; checked at each edge once framed
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            slot_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= lr_edge && (state_q != SYNC) && (slot_cnt_q + 1'b1 != SLOT_LEN);
            if (rise) slot_cnt_q <= lr_edge ? '0 : ((slot_cnt_q != '1) ? slot_cnt_q + 1'b1 : slot_cnt_q);
        end
    end
    assign frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_i2s_slave_receiver.sv
// tb_i2s_slave_receiver: randomized and directed frames against a bit-stream reference model
module tb_i2s_slave_receiver;
    import i2s_pkg::*;
    logic clk = 1'b0;
    logic arst = 1'b1, i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_sdata = 1'b0;
    logic out_ready = 1'b0, overflow_clr = 1'b0;
    logic [FRAME_BITS-1:0] out_data;
    logic out_valid, overflow;
    int n_checks = 0, n_fail = 0, vcyc = 0;
    logic carry = 1'b0;
    logic [FRAME_BITS-1:0] got[$];
    logic [FRAME_BITS-1:0] exp_q[$];
`ifdef I2S_RX_FRAMEERR_EN
    logic frame_err;
    int ferr_cnt = 0;
    always @(posedge clk) if (frame_err) ferr_cnt++;
`endif

    always #5 clk = ~clk;

    i2s_slave_receiver dut (
        .clk          (clk),
        .arst         (arst),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
`ifdef I2S_RX_FRAMEERR_EN
        .frame_err    (frame_err),
`endif
        .overflow_clr (overflow_clr)
    );

    always @(posedge clk) if (out_valid && out_ready) got.push_back(out_data);
    always @(posedge clk) if (out_valid) vcyc++;

    // reference: the 24-bit sample a receiver must recover from slot bits 0..min(s,24)-1
    function automatic logic [23:0] exp_sample(input logic [31:0] w, input int n, input int s);
        logic [23:0] r = '0;
        for (int k = 0; k < 24; k++) if (k < s && k < n) r[23-k] = w[n-1-k];
        return r;
    endfunction

    function automatic logic [FRAME_BITS-1:0] peek(input int i);
        return (i < got.size()) ? got[i] : 'x;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic lr, input logic d, input bit align = 0);
        i2s_bclk = 1'b0; i2s_lrclk = lr; i2s_sdata = d;
        wait_clk(8);
        i2s_bclk = 1'b1;
        if (align) begin
            wait_clk(2); out_ready = 1'b1; wait_clk(1); out_ready = 1'b0; wait_clk(5);
        end else wait_clk(8);
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] w, input int n, input int s, input bit align_first = 0);
        for (int k = 0; k < s; k++) begin
            send_bit(lr, carry, align_first && k == 0);
            carry = 1'b0;
            if (k < n) carry = w[n-1-k];
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input int sl, input int sr);
        send_slot(1'b0, l, n, sl);
        send_slot(1'b1, r, n, sr);
        exp_q.push_back({exp_sample(l, n, sl), exp_sample(r, n, sr)});
    endtask

    task automatic start_stream();
        carry = 1'b0;
        send_slot(1'b1, $urandom, 24, 7);
    endtask

    task automatic tail();
        send_bit(1'b0, carry);
        send_bit(1'b0, 1'b0);
        wait_clk(8);
    endtask

    task automatic do_reset();
        arst = 1'b1; i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
        out_ready = 1'b0; overflow_clr = 1'b0;
        wait_clk(3);
        arst = 1'b0;
        wait_clk(2);
        got.delete(); exp_q.delete(); vcyc = 0;
    endtask

    task automatic test_reset();
        wait_clk(3);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`ifdef I2S_RX_FRAMEERR_EN
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
`endif
    endtask

    task automatic test_basic();
        do_reset(); out_ready = 1'b1;
        start_stream();
        send_frame(32'hABCDEF, 32'h123456, 24, 32, 32);
        send_frame(32'h000001, 32'hFFFFFF, 24, 32, 32);
        tail();
        n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", got.size()); end
        n_checks++; if (peek(0) !== 48'hABCDEF123456) begin n_fail++; $display("FAIL basic_f1: got %h expected abcdef123456", peek(0)); end
        n_checks++; if (peek(1) !== 48'h000001FFFFFF) begin n_fail++; $display("FAIL basic_f2: got %h expected 000001ffffff", peek(1)); end
        n_checks++; if (vcyc != 2) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d expected 2", vcyc); end
    endtask

    task automatic test_random();
        do_reset(); out_ready = 1'b1;
        start_stream();
        for (int i = 0; i < 4; i++) send_frame($urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF, 24, 32, 32);
        tail();
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL random_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (peek(i) !== exp_q[i]) begin n_fail++; $display("FAIL random_frame%0d: got %h expected %h", i, peek(i), exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] l1, r1;
        logic [FRAME_BITS-1:0] f1;
        do_reset();
        l1 = $urandom & 32'hFFFFFF; r1 = $urandom & 32'hFFFFFF;
        f1 = {l1[23:0], r1[23:0]};
        start_stream();
        send_frame(l1, r1, 24, 32, 32);
        send_slot(1'b0, $urandom, 24, 32);
        n_checks++; if (out_valid !== 1'b1 || out_data !== f1) begin n_fail++; $display("FAIL ovf_hold1: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, f1); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        send_slot(1'b1, $urandom, 24, 32);
        send_slot(1'b0, $urandom, 24, 32);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        send_slot(1'b1, $urandom, 24, 32);
        tail();
        n_checks++; if (out_valid !== 1'b1 || out_data !== f1) begin n_fail++; $display("FAIL ovf_hold3: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, f1); end
        out_ready = 1'b1; wait_clk(1); out_ready = 1'b0; wait_clk(2);
        n_checks++; if (got.size() != 1 || peek(0) !== f1) begin n_fail++; $display("FAIL ovf_xfer: got n=%0d d=%h expected n=1 d=%h", got.size(), peek(0), f1); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_valid_drop: got %b expected 0", out_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        overflow_clr = 1'b1; wait_clk(1); overflow_clr = 1'b0; wait_clk(1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] la, ra, lb, rb;
        do_reset();
        la = $urandom & 32'hFFFFFF; ra = $urandom & 32'hFFFFFF;
        lb = $urandom & 32'hFFFFFF; rb = $urandom & 32'hFFFFFF;
        start_stream();
        send_frame(la, ra, 24, 32, 32);
        send_frame(lb, rb, 24, 32, 32);
        send_slot(1'b0, $urandom, 24, 32, 1'b1);
        n_checks++; if (got.size() != 1 || peek(0) !== {la[23:0], ra[23:0]}) begin n_fail++; $display("FAIL b2b_xfer: got n=%0d d=%h expected n=1 d=%h", got.size(), peek(0), {la[23:0], ra[23:0]}); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== {lb[23:0], rb[23:0]}) begin n_fail++; $display("FAIL b2b_load: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, {lb[23:0], rb[23:0]}); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_short_slot();
        do_reset(); out_ready = 1'b1;
        start_stream();
        send_frame(32'hA5A5, 32'h5A5A, 16, 16, 16);
        tail();
        n_checks++; if (got.size() != 1 || peek(0) !== 48'hA5A5005A5A00) begin n_fail++; $display("FAIL short_slot: got n=%0d d=%h expected n=1 d=a5a5005a5a00", got.size(), peek(0)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        do_reset();
        w = $urandom & 32'hFFFFFF;
        start_stream();
        send_frame($urandom | 32'h800000, $urandom, 24, 32, 32);
        send_slot(1'b0, w, 24, 10);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
        arst = 1'b1; #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_async_clear: got v=%b d=%h o=%b expected all 0", out_valid, out_data, overflow); end
        wait_clk(2); arst = 1'b0; out_ready = 1'b1; got.delete(); exp_q.delete();
        for (int k = 10; k < 32; k++) begin
            send_bit(1'b0, carry);
            carry = 1'b0;
            if (k < 24) carry = w[23-k];
        end
        send_slot(1'b1, $urandom, 24, 32);
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL mid_no_partial: got %0d frames expected 0", got.size()); end
        send_frame($urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF, 24, 32, 32);
        tail();
        n_checks++; if (got.size() != 1 || peek(0) !== exp_q[0]) begin n_fail++; $display("FAIL mid_recover: got n=%0d d=%h expected n=1 d=%h", got.size(), peek(0), exp_q[0]); end
    endtask

`ifdef I2S_RX_FRAMEERR_EN
    task automatic test_frame_err();
        do_reset(); out_ready = 1'b1; ferr_cnt = 0;
        start_stream();
        send_frame($urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF, 24, 32, 32);
        send_frame($urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF, 24, 32, 31);
        n_checks++; if (ferr_cnt != 0) begin n_fail++; $display("FAIL ferr_early: got %0d expected 0", ferr_cnt); end
        send_frame($urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF, 24, 32, 32);
        tail();
        n_checks++; if (ferr_cnt != 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt); end
        n_checks++; if (got.size() != 3 || peek(1) !== exp_q[1]) begin n_fail++; $display("FAIL ferr_data: got n=%0d d=%h expected n=3 d=%h", got.size(), peek(1), exp_q[1]); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_overflow();
        test_back_to_back();
        test_short_slot();
        test_reset_mid();
`ifdef I2S_RX_FRAMEERR_EN
        test_frame_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_slave_receiver.md
Name: i2s_slave_receiver

Overview:
- I2S receive path: the counterpart of the on-chip I2S master transmitter.
- Samples externally driven bclk/lrclk/sdata in the system clk domain and deserialises 24-bit left/right samples.
- Presents each completed stereo frame as one 48-bit word on a valid/ready interface; the codebase FIFO (sfifo, BW=48) or a test sink consumes it.
- Intended for loopback (i2s_master -> i2s_slave_receiver) and for ADC/codec input.

Parameters:
- SAMPLE_BITS, 24, bits captured per channel, MSB-first.
- SLOT_BITS, 32, nominal bclk periods per channel slot; used only for the optional framing check.

Ports:
- clk  in  1  system clock; must be >= 4x bclk frequency.
- arst  in  1  asynchronous, active-high reset.
- i2s_bclk  in  1  serial bit clock, asynchronous to clk.
- i2s_lrclk  in  1  word select; 0 = left, 1 = right.
- i2s_sdata  in  1  serial data.
- out_data  out  2*SAMPLE_BITS  {left, right}; left occupies the MSBs.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts a frame.
- overflow  out  1  sticky flag: a frame was dropped.
- overflow_clr  in  1  one-cycle pulse that clears overflow.
- frame_err  out  1  one-cycle pulse; exists only with I2S_RX_FRAMEERR_EN.

Behaviour:
- Input synchronisation: bclk, lrclk and sdata each pass through a 2-FF synchroniser. A bclk rising edge is detected from the synchronised bclk (previous 0, current 1), producing a one-clk strobe `rise`. All logic below advances only on `rise`, which also samples lrclk and sdata.
- Slot timing (standard I2S, one-bit delay):
  - On a `rise` where the sampled lrclk differs from lr_prev, that bit belongs to the previous slot. bit_cnt is set to 0, so the next `rise` carries the MSB.
  - When bit_cnt < SAMPLE_BITS: shreg[SAMPLE_BITS-1-bit_cnt] <= sdata, then bit_cnt increments.
  - Otherwise bit_cnt saturates and the bit is ignored.
  - shreg clears at slot start. A short slot therefore yields zero-filled LSBs; bits beyond SAMPLE_BITS are ignored.
- FSM:
  - SYNC (reset state): discards all bits until lrclk falls (1 -> 0), then goes to LEFT.
  - LEFT: on lrclk rising, left_hold <= shreg, go to RIGHT.
  - RIGHT: on lrclk falling, the frame {left_hold, shreg} completes, go to LEFT.
  - The first partial frame after reset is never output.
- Output handshake:
  - When a frame completes, out_data and out_valid=1 are registered on the next clk.
  - Latency from the completing bclk rising edge at the pin to out_valid is at most 5 clk.
  - out_data is stable while out_valid && !out_ready.
  - A transfer occurs when out_valid && out_ready; out_valid drops on the next clk unless a new frame loads.
- Overflow and simultaneous events:
  - Frame completes while out_valid && !out_ready: the new frame is dropped, the held data is kept, and overflow <= 1.
  - Frame completes in the same cycle as a transfer: the new frame loads, out_valid stays 1, no overflow.
  - overflow_clr and a new overflow in the same cycle: set wins.
- Reset: arst at any time forces out_valid=0, out_data=0, overflow=0, frame_err=0, all shift registers, counters and lr_prev to 0, FSM to SYNC, and synchroniser flops to 0. Capture restarts at the next lrclk falling edge.

Optional Feature:
- I2S_RX_FRAMEERR_EN defined: on every lrclk transition outside SYNC, if the previous slot length != SLOT_BITS, frame_err pulses high for one clk. Slot length counts from the MSB `rise` through the one-bit-delay `rise` inclusive, so a nominal slot counts SLOT_BITS. Data capture is unaffected.
- Undefined: no frame_err port, no slot-length counter.

Decomposition:
- Package i2s_pkg: SAMPLE_BITS/SLOT_BITS defaults, rx_state_t enum {SYNC, LEFT, RIGHT}, frame width constant 2*SAMPLE_BITS.
- One sub-module, i2s_input_sync: 2-FF synchronisers for the three pins plus the bclk rising-edge strobe. Outputs: rise, lrclk_s, sdata_s.

Test Plan:
- Reset; bclk = clk/16, 32-bit slots; send frames L=0xABCDEF, R=0x123456 and L=0x000001, R=0xFFFFFF with out_ready=1. Required: out_data=0xABCDEF123456 then 0x000001FFFFFF, one valid cycle each; the leading partial frame produces nothing.
- Hold out_ready=0 across 3 frames. Required: out_data stays at frame 1, overflow=1 after frame 2; raise out_ready, the frame 1 transfer occurs, overflow stays 1 until the overflow_clr pulse.
- Align out_ready so the transfer coincides with the next frame completion. Required: out_valid remains 1, out_data updates to the new frame, overflow=0.
- 16-bit slots with L=0xA5A5, R=0x5A5A. Required: out_data=0xA5A5005A5A00.
- Assert arst mid-LEFT slot. Required: all outputs 0 immediately; no output until lrclk falls, then a full frame is correct.
- With I2S_RX_FRAMEERR_EN: one 31-bit right slot among 32-bit slots. Required: exactly one frame_err pulse at the following lrclk falling edge; data still captured.
